// File: rtl/stream_fifo_if.sv
// Stream FIFO bus: upstream push handshake, downstream pop handshake, flush and fill-level status.
// The slave modport is the FIFO side and the master modport is the side that drives the FIFO.
interface stream_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3
);
  logic                  i_flush;
  logic [DATA_WIDTH-1:0] i_push_data;
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_ready;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_pop_data;
  logic [PTR_WIDTH:0]    o_count;
  logic                  o_almost_full;
  logic                  o_almost_empty;

  modport slave (
    input  i_flush, i_push_data, i_valid, i_ready,
    output o_ready, o_valid, o_pop_data, o_count, o_almost_full, o_almost_empty
  );

  modport master (
    output i_flush, i_push_data, i_valid, i_ready,
    input  o_ready, o_valid, o_pop_data, o_count, o_almost_full, o_almost_empty
  );
endinterface

// File: rtl/stream_fifo.sv
// Valid/ready FIFO with optional zero-latency bypass when empty, and accept-while-full when a pop happens.
// Latency is 1 cycle when stored, 0 on bypass; o_ready drops when full unless full-pass is enabled.
module stream_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int PTR_WIDTH    = 3,
  parameter int BYPASS_EN    = 1,
  parameter int FULL_PASS_EN = 1,
  parameter int AF_LEVEL     = (1 << PTR_WIDTH) - 1,
  parameter int AE_LEVEL     = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  stream_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam bit BYP   = (BYPASS_EN != 0);
  localparam bit FPASS = (FULL_PASS_EN != 0);
  localparam logic [PTR_WIDTH:0] AF_LVL  = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] AE_LVL  = (PTR_WIDTH+1)'(AE_LEVEL);
  localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_range
    $error("stream_fifo: AF_LEVEL must be within 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_range
    $error("stream_fifo: AE_LEVEL must be within 0..DEPTH-1");
  end

  logic [PTR_WIDTH:0]    head_q, head_d;
  logic [PTR_WIDTH:0]    tail_q, tail_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_WIDTH-1:0] head_addr;
  logic [PTR_WIDTH-1:0] tail_addr;
  logic empty, full;
  logic valid_c, ready_c;
  logic push, pop, bypass, wr_en, rd_en;

  assign head_addr = head_q[PTR_WIDTH-1:0];
  assign tail_addr = tail_q[PTR_WIDTH-1:0];

  always_comb begin
    empty   = (head_q == tail_q);
    full    = (head_addr == tail_addr) && (head_q[PTR_WIDTH] != tail_q[PTR_WIDTH]);
    valid_c = 1'b0;
    ready_c = 1'b0;
    // Reset and flush both block any transfer in the current cycle.
    if (!i_rst && !bus.i_flush) begin
      valid_c = !empty || (BYP && bus.i_valid);
      ready_c = !full  || (FPASS && bus.i_ready);
    end
    push   = bus.i_valid & ready_c;
    pop    = valid_c & bus.i_ready;
    bypass = empty & pop;
    wr_en  = push & ~bypass;
    rd_en  = pop & ~bypass;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (wr_en) tail_d = tail_q + PTR_ONE;
    if (rd_en) head_d = head_q + PTR_ONE;
    if (wr_en && !rd_en) count_d = count_q + PTR_ONE;
    if (rd_en && !wr_en) count_d = count_q - PTR_ONE;
    if (bus.i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset and flush; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[tail_addr] <= bus.i_push_data;
  end

  assign bus.o_valid        = valid_c;
  assign bus.o_ready        = ready_c;
  assign bus.o_pop_data     = (empty && BYP) ? bus.i_push_data : mem_q[head_addr];
  assign bus.o_count        = count_q;
  assign bus.o_almost_full  = (count_q >= AF_LVL);
  assign bus.o_almost_empty = (count_q <= AE_LVL);

endmodule

// File: tb/tb_stream_fifo.sv
// Drives two FIFOs (bypass/full-pass on and off) with identical stimulus and checks each against a queue model.
module tb_stream_fifo;
  localparam int DW    = 8;
  localparam int PW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  stream_fifo_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) ifa ();
  stream_fifo_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) ifb ();

  stream_fifo #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .BYPASS_EN(1), .FULL_PASS_EN(1),
                .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
  stream_fifo #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .BYPASS_EN(0), .FULL_PASS_EN(0),
                .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the number of stored words and the front word alone.
  task automatic check_dut(input string t, input int sz, input logic [7:0] front,
                           input bit bp, input bit fp,
                           input logic r, input logic f, input logic v,
                           input logic [7:0] d, input logic rd,
                           input logic ov, input logic orr, input logic [7:0] od,
                           input logic [PW:0] oc, input logic oaf, input logic oae,
                           output bit pop_q, output bit push_q);
    bit ev, er;
    if (r || f) begin
      ev = 1'b0;
      er = 1'b0;
    end else begin
      ev = (sz > 0) || (bp && v);
      er = (sz < DEPTH) || (fp && rd);
    end
    chk({t, " o_valid"}, 32'(ov), 32'(ev));
    chk({t, " o_ready"}, 32'(orr), 32'(er));
    if (ev) chk({t, " o_pop_data"}, 32'(od), 32'(sz > 0 ? front : d));
    chk({t, " o_count"}, 32'(oc), 32'(sz));
    chk({t, " o_almost_full"}, 32'(oaf), 32'(sz >= AF));
    chk({t, " o_almost_empty"}, 32'(oae), 32'(sz <= AE));
    pop_q  = ev && rd && (sz > 0);
    push_q = v && er && !(ev && rd && (sz == 0));
  endtask

  task automatic step(input logic r, input logic f, input logic v,
                      input logic [7:0] d, input logic rd);
    bit pa, ua, pb, ub;
    @(negedge clk);
    rst = r;
    ifa.i_flush = f; ifa.i_valid = v; ifa.i_push_data = d; ifa.i_ready = rd;
    ifb.i_flush = f; ifb.i_valid = v; ifb.i_push_data = d; ifb.i_ready = rd;
    #1;
    check_dut("A", qa.size(), (qa.size() > 0) ? qa[0] : 8'h00, 1'b1, 1'b1, r, f, v, d, rd,
              ifa.o_valid, ifa.o_ready, ifa.o_pop_data, ifa.o_count,
              ifa.o_almost_full, ifa.o_almost_empty, pa, ua);
    check_dut("B", qb.size(), (qb.size() > 0) ? qb[0] : 8'h00, 1'b0, 1'b0, r, f, v, d, rd,
              ifb.o_valid, ifb.o_ready, ifb.o_pop_data, ifb.o_count,
              ifb.o_almost_full, ifb.o_almost_empty, pb, ub);
    if (r || f) qa.delete();
    else begin
      if (pa) void'(qa.pop_front());
      if (ua) qa.push_back(d);
    end
    if (r || f) qb.delete();
    else begin
      if (pb) void'(qb.pop_front());
      if (ub) qb.push_back(d);
    end
  endtask

  initial begin
    logic [7:0] fill_dat [4];
    logic rr, ff, vv, rdy;
    fill_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1;
    ifa.i_flush = 1'b0; ifa.i_valid = 1'b0; ifa.i_push_data = 8'h00; ifa.i_ready = 1'b0;
    ifb.i_flush = 1'b0; ifb.i_valid = 1'b0; ifb.i_push_data = 8'h00; ifb.i_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held with an active handshake and a flush: no transfer may happen.
    step(H, L, H, 8'hEE, H);
    step(H, H, H, 8'hEE, H);

    // Fill to full with downstream stalled, then attempt one more push.
    for (int i = 0; i < 4; i++) step(L, L, H, fill_dat[i], L);
    step(L, L, H, 8'h99, L);
    repeat (5) step(L, L, L, 8'h00, H);

    // Bypass on an empty queue.
    step(L, L, H, 8'hA5, H);
    step(L, L, L, 8'h00, H);

    // Push while full with downstream ready.
    for (int i = 0; i < 4; i++) step(L, L, H, fill_dat[i], L);
    step(L, L, H, 8'h55, H);
    step(L, L, L, 8'h00, L);
    repeat (5) step(L, L, L, 8'h00, H);

    // Steady push/pop at a level of two, wrapping the pointers several times.
    step(L, L, H, 8'hE1, L);
    step(L, L, H, 8'hE2, L);
    for (int i = 1; i <= 10; i++) step(L, L, H, 8'(i), H);
    repeat (3) step(L, L, L, 8'h00, H);

    // Flush with an active handshake.
    for (int i = 0; i < 3; i++) step(L, L, H, fill_dat[i], L);
    step(L, H, H, 8'hF0, H);
    step(L, L, L, 8'h00, L);

    // Reset and flush together mid-operation, then confirm no stale data.
    step(L, L, H, 8'hC1, L);
    step(L, L, H, 8'hC2, L);
    step(H, H, H, 8'hF1, H);
    step(L, L, H, 8'h77, L);
    step(L, L, L, 8'h00, H);
    step(L, L, L, 8'h00, H);

    // Random traffic: push-heavy, then pop-heavy, with rare flush and reset.
    for (int i = 0; i < 400; i++) begin
      rr  = ($urandom_range(0, 99) == 0);
      ff  = ($urandom_range(0, 39) == 0);
      vv  = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rdy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(rr, ff, vv, 8'($urandom), rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 Parameter PTR_WIDTH, default 3, address width; DEPTH = 2**PTR_WIDTH entries.
REQ-003 Parameter BYPASS_EN, default 1, 1 enables empty-queue bypass.
REQ-004 Parameter FULL_PASS_EN, default 1, 1 enables accept-while-full when a pop occurs in the same cycle.
REQ-005 Parameter AF_LEVEL, default DEPTH-1, almost-full threshold; legal range 1..DEPTH, else elaboration error.
REQ-006 Parameter AE_LEVEL, default 1, almost-empty threshold; legal range 0..DEPTH-1, else elaboration error.
REQ-007 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-008 i_rst  input  1  reset, synchronous, active-high.
REQ-009 i_flush  input  1  synchronous queue clear.
REQ-010 i_push_data  input  DATA_WIDTH  upstream data.
REQ-011 i_valid  input  1  upstream valid.
REQ-012 o_ready  output  1  ready to upstream.
REQ-013 i_ready  input  1  downstream ready.
REQ-014 o_valid  output  1  valid to downstream.
REQ-015 o_pop_data  output  DATA_WIDTH  downstream data.
REQ-016 o_count  output  PTR_WIDTH+1  stored-entry count, 0..DEPTH.
REQ-017 o_almost_full  output  1  o_count >= AF_LEVEL.
REQ-018 o_almost_empty  output  1  o_count <= AE_LEVEL.

Function
REQ-019 Head/tail pointers SHALL be PTR_WIDTH+1 bits (wrap bit + address); full = addresses equal and wrap bits differ; empty = pointers equal; wrap modulo 2*DEPTH.
REQ-020 push = i_valid & o_ready; pop = o_valid & i_ready; transfers SHALL take effect on the rising edge of the handshake cycle.
REQ-021 o_valid SHALL be ~empty; when empty and BYPASS_EN=1, o_valid SHALL equal i_valid.
REQ-022 o_ready SHALL be ~full; when full and FULL_PASS_EN=1, o_ready SHALL equal i_ready.
REQ-023 o_pop_data SHALL be mem[head address]; when empty and BYPASS_EN=1, SHALL be i_push_data (combinational).
REQ-024 Bypass (empty, BYPASS_EN=1, i_valid=1, i_ready=1): no write, pointers and count unchanged, zero-cycle latency.
REQ-025 Empty, i_valid=1, i_ready=0 (or BYPASS_EN=0): data written at tail, tail+1, count+1; earliest o_valid next cycle.
REQ-026 Non-bypass push with pop (including full-pass): write at tail, tail+1, head+1, count unchanged.
REQ-027 Push only: count+1; pop only: count-1; count SHALL never exceed DEPTH nor go below 0.
REQ-028 Data SHALL pop in exact push order across pointer wrap-around.
REQ-029 o_count, o_almost_full, o_almost_empty SHALL depend only on registered state, not on same-cycle inputs.
REQ-030 i_flush=1: o_valid=0, o_ready=0 that cycle (no transfer); next edge head=tail=0, count=0; memory contents not cleared.
REQ-031 Storage memory SHALL NOT be reset; only pointers and count are.

Reset
REQ-032 i_rst=1 at rising edge: head=tail=0, count=0; i_rst SHALL take priority over i_flush and any handshake.
REQ-033 While i_rst=1: o_valid=0, o_ready=0; first cycle after release: o_count=0, o_almost_empty=1, o_almost_full=0, o_ready=1.
REQ-034 Reset mid-operation SHALL discard all stored entries; no stale data SHALL be popped afterwards.

Verification (DATA_WIDTH=8, PTR_WIDTH=2, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-035 Fill/drain: push 0x11,0x22,0x33,0x44 with i_ready=0 -> o_count 1,2,3,4; o_almost_full from count 3; o_ready=0 at count 4 when i_ready=0; drain yields 0x11..0x44, o_almost_empty at count<=1.
REQ-036 Bypass: empty, i_valid=1, data 0xA5, i_ready=1 -> same cycle o_valid=1, o_pop_data=0xA5, o_count stays 0; with BYPASS_EN=0 -> o_valid=0, 0xA5 valid next cycle, o_count=1.
REQ-037 Full-pass: full with 0x11..0x44, push 0x55 with i_ready=1 -> o_ready=1, 0x11 popped, o_count stays 4, next o_pop_data=0x22; with FULL_PASS_EN=0 -> o_ready=0, count 3 next cycle.
REQ-038 Wrap: count=2, continuous push/pop of 0x01..0x0A over 10 cycles -> o_count holds 2, output order preserved across wrap.
REQ-039 Flush: count=3, i_flush=1 with i_valid=i_ready=1 for one cycle -> o_valid=o_ready=0 that cycle, next cycle o_count=0, o_valid=0 (BYPASS_EN=0).
REQ-040 Reset mid-op: count=2, i_rst=1 and i_flush=1 together -> o_count=0 next cycle; after release push 0x77 -> first popped word is 0x77.
